// File: rtl/cavlc_blk_sched_pkg.sv
// Shared types and constants for the CAVLC block scheduler.
package cavlc_blk_sched_pkg;

  localparam int COEF_W = 8;
  localparam int BLK_N  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  typedef logic signed [COEF_W-1:0] coef_t;
  // Element rc lives at bits [8*(4r+c) +: 8].
  typedef coef_t [BLK_N-1:0] blk_t;

  function automatic logic [BLK_N-1:0] blk_bit(input logic [3:0] idx);
    return {{(BLK_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/cavlc_blk_sched_if.sv
// Block input stream and CAVLC core handshake bundled as one interface.
interface cavlc_blk_sched_if;
  import cavlc_blk_sched_pkg::*;

  logic in_valid;
  logic in_ready;
  blk_t in_coef;
  logic cavlc_valid;
  blk_t cavlc_coef;
  logic cavlc_done;

  modport master (
    output in_valid, in_coef, cavlc_done,
    input  in_ready, cavlc_valid, cavlc_coef
  );

  modport slave (
    input  in_valid, in_coef, cavlc_done,
    output in_ready, cavlc_valid, cavlc_coef
  );

endinterface

// File: rtl/cavlc_blk_fifo.sv
// Small circular queue of quantized blocks; head is visible without a pop.
module cavlc_blk_fifo
  import cavlc_blk_sched_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  blk_t             push_data,
  input  logic             pop,
  output blk_t             head,
  output logic [CNT_W-1:0] count
);

  blk_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_fire;
  logic             pop_fire;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on the registered count, so no combinational path from pop.
  assign push_ready = (count_reg < CNT_W'(DEPTH));
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop && (count_reg != '0);
  assign head       = mem[rd_ptr_reg];
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop_fire)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/cavlc_blk_sched.sv
// Feeds queued 4x4 blocks to a CAVLC core, skipping all-zero blocks and
// building the per-macroblock coded-block map.
module cavlc_blk_sched
  import cavlc_blk_sched_pkg::*;
#(
  parameter int BLK_PER_MB = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst,
  cavlc_blk_sched_if.slave    bus,
  output logic [3:0]          blk_idx,
  output logic                mb_done,
  output logic [BLK_N-1:0]    mb_cbp,
  output logic                busy,
  output logic                err_timeout
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t           state_reg;
  logic             cavlc_valid_reg;
  blk_t             cavlc_coef_reg;
  logic [3:0]       blk_idx_reg;
  logic             mb_done_reg;
  logic [BLK_N-1:0] mb_cbp_reg;
  logic [BLK_N-1:0] cbp_acc_reg;
  logic             err_timeout_reg;
  logic [TO_W-1:0]  wait_cnt_reg;

  blk_t             head;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pop_n;
  logic             pop;
  logic [BLK_N-1:0] coef_nz;
  logic             head_zero;
  logic             wait_last;
  logic             blk_complete;
  logic             more_queued;
  logic             last_blk;
  logic [BLK_N-1:0] blk_mask;
  logic [BLK_N-1:0] cbp_final;

  cavlc_blk_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (bus.in_coef),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  for (genvar gi = 0; gi < BLK_N; gi++) begin : g_nz
    assign coef_nz[gi] = (head[gi] != '0);
  end

  assign head_zero = ~|coef_nz;
  assign wait_last = (wait_cnt_reg == TO_W'(TIMEOUT - 1));
  assign last_blk  = (blk_idx_reg == 4'(BLK_PER_MB - 1));
  assign blk_mask  = blk_bit(blk_idx_reg);

  // Zero blocks are dropped straight from CHECK; coded blocks leave the queue in ISSUE.
  assign pop = ((state_reg == CHECK) && (count != '0) && head_zero) ||
               (state_reg == ISSUE);
  assign pop_n       = {{(CNT_W-1){1'b0}}, pop};
  assign more_queued = (count > pop_n);

  assign blk_complete =
      ((state_reg == CHECK) && (count != '0) && head_zero) ||
      ((state_reg == WAIT) && (bus.cavlc_done || wait_last));

  // A coded block already set its bit in ISSUE; a skipped block clears it here.
  assign cbp_final = (state_reg == CHECK) ? (cbp_acc_reg & ~blk_mask) : cbp_acc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cavlc_valid_reg <= 1'b0;
      cavlc_coef_reg  <= '0;
      blk_idx_reg     <= '0;
      mb_done_reg     <= 1'b0;
      mb_cbp_reg      <= '0;
      cbp_acc_reg     <= '0;
      err_timeout_reg <= 1'b0;
      wait_cnt_reg    <= '0;
    end else begin
      cavlc_valid_reg <= 1'b0;
      mb_done_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (count != '0) state_reg <= CHECK;
        end
        CHECK: begin
          if (count == '0) begin
            state_reg <= IDLE;
          end else if (!head_zero) begin
            cavlc_valid_reg <= 1'b1;
            cavlc_coef_reg  <= head;
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          cbp_acc_reg  <= cbp_acc_reg | blk_mask;
          wait_cnt_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (!bus.cavlc_done) begin
            if (wait_last) err_timeout_reg <= 1'b1;
            else           wait_cnt_reg    <= wait_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (blk_complete) begin
        state_reg <= more_queued ? CHECK : IDLE;
        if (last_blk) begin
          mb_done_reg <= 1'b1;
          mb_cbp_reg  <= cbp_final;
          blk_idx_reg <= '0;
          cbp_acc_reg <= '0;
        end else begin
          blk_idx_reg <= blk_idx_reg + 4'd1;
          cbp_acc_reg <= cbp_final;
        end
      end
    end
  end

  assign bus.cavlc_valid = cavlc_valid_reg;
  assign bus.cavlc_coef  = cavlc_coef_reg;
  assign blk_idx         = blk_idx_reg;
  assign mb_done         = mb_done_reg;
  assign mb_cbp          = mb_cbp_reg;
  assign err_timeout     = err_timeout_reg;
  assign busy            = (state_reg != IDLE) || (count != '0);

endmodule

// File: tb/tb_cavlc_blk_sched.sv
// Directed bench for cavlc_blk_sched with a scoreboard of issued blocks.
module tb_cavlc_blk_sched;
  import cavlc_blk_sched_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  blk_idx;
  logic        mb_done;
  logic [15:0] mb_cbp;
  logic        busy;
  logic        err_timeout;

  cavlc_blk_sched_if bus();

  cavlc_blk_sched #(
    .BLK_PER_MB (16),
    .FIFO_DEPTH (2),
    .TIMEOUT    (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .blk_idx     (blk_idx),
    .mb_done     (mb_done),
    .mb_cbp      (mb_cbp),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   issue_count = 0;
  int   mb_done_count = 0;
  int   last_issue_cyc = 0;
  int   min_gap = 1000;
  int   done_delay = 0;
  blk_t exp_q[$];
  int   spec_vals[16] = '{2, -2, -1, 1, -1, 2, -1, -1, 1, -1, 0, 0, -1, 1, 0, 0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_blk(input string tag, input blk_t obs, input blk_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic blk_t rand_blk(input int tag);
    blk_t b;
    for (int i = 0; i < BLK_N; i++) b[i] = coef_t'($urandom_range(0, 255));
    b[0] = coef_t'((tag % 100) + 1);
    return b;
  endfunction

  // Scoreboard: every start pulse must carry the oldest outstanding coded block.
  initial forever begin
    @(negedge clk);
    if (bus.cavlc_valid === 1'b1) begin
      if (issue_count > 0 && (cyc - last_issue_cyc) < min_gap) min_gap = cyc - last_issue_cyc;
      last_issue_cyc = cyc;
      issue_count++;
      check_int("sb_nonempty", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_blk("sb_coef", bus.cavlc_coef, exp_q.pop_front());
    end
    if (mb_done === 1'b1) mb_done_count++;
  end

  // Core model: answers each start pulse done_delay cycles later (0 = never).
  initial forever begin
    @(negedge clk);
    if (bus.cavlc_valid === 1'b1 && done_delay > 0) begin
      repeat (done_delay) @(negedge clk);
      bus.cavlc_done = 1'b1;
      @(negedge clk);
      bus.cavlc_done = 1'b0;
    end
  end

  task automatic push_blk(input blk_t b, output int acc_cyc, output int stalls);
    bus.in_valid = 1'b1;
    bus.in_coef  = b;
    acc_cyc = -1;
    stalls  = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready === 1'b1) begin
        acc_cyc = cyc;
        if (b != '0) exp_q.push_back(b);
        @(negedge clk);
        break;
      end
      stalls++;
      @(negedge clk);
    end
    check_int("push_accept", int'(acc_cyc >= 0), 1);
  endtask

  task automatic wait_valid(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      if (bus.cavlc_valid === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    check_int("wait_valid", int'(t >= 0), 1);
  endtask

  task automatic wait_idle(input int limit);
    int ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    check_int("wait_idle", ok, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    blk_t b;
    blk_t bb;
    int   acc;
    int   stl;
    int   t;
    int   i0;
    int   m0;
    int   first_stall;

    rst = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_coef    = '0;
    bus.cavlc_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_int("rst_in_ready", int'(bus.in_ready), 1);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_blk_idx", int'(blk_idx), 0);
    check_int("rst_cavlc_valid", int'(bus.cavlc_valid), 0);
    check_blk("rst_cavlc_coef", bus.cavlc_coef, '0);
    check_int("rst_mb_cbp", int'(mb_cbp), 0);
    check_int("rst_err", int'(err_timeout), 0);

    // Spurious done while idle
    bus.cavlc_done = 1'b1;
    @(negedge clk);
    bus.cavlc_done = 1'b0;
    @(negedge clk);
    check_int("spur_blk_idx", int'(blk_idx), 0);
    check_int("spur_busy", int'(busy), 0);
    check_int("spur_issue", issue_count, 0);
    check_int("spur_mb_done", mb_done_count, 0);

    // Single coded block, done after 5 cycles
    done_delay = 5;
    for (int i = 0; i < BLK_N; i++) b[i] = coef_t'(spec_vals[i]);
    push_blk(b, acc, stl);
    bus.in_valid = 1'b0;
    wait_valid(20, t);
    check_int("single_latency", t - acc, 3);
    check_blk("single_coef", bus.cavlc_coef, b);
    repeat (5) @(negedge clk);
    check_blk("single_coef_hold", bus.cavlc_coef, b);
    check_int("single_idx_before", int'(blk_idx), 0);
    @(negedge clk);
    check_int("single_idx_after", int'(blk_idx), 1);
    check_int("single_no_mb_done", mb_done_count, 0);
    wait_idle(20);

    // Full macroblock, block 5 all-zero, done one cycle after each issue
    do_reset();
    done_delay = 1;
    i0 = issue_count;
    m0 = mb_done_count;
    min_gap = 1000;
    for (int i = 0; i < 16; i++) begin
      bb = (i == 5) ? blk_t'('0) : rand_blk(i + 1);
      push_blk(bb, acc, stl);
    end
    bus.in_valid = 1'b0;
    wait_idle(300);
    check_int("mb_issues", issue_count - i0, 15);
    check_int("mb_done_pulses", mb_done_count - m0, 1);
    check_int("mb_cbp", int'(mb_cbp), 32'h0000FFDF);
    check_int("mb_blk_idx", int'(blk_idx), 0);
    check_int("mb_min_gap", min_gap, 3);
    check_int("mb_sb_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check_int("mb_cbp_hold", int'(mb_cbp), 32'h0000FFDF);

    // Continuous input against a slow core
    do_reset();
    done_delay = 10;
    i0 = issue_count;
    first_stall = -1;
    for (int i = 0; i < 6; i++) begin
      push_blk(rand_blk(40 + i), acc, stl);
      if (stl > 0 && first_stall < 0) first_stall = i;
    end
    bus.in_valid = 1'b0;
    wait_idle(500);
    check_int("bp_first_stall", first_stall, 2);
    check_int("bp_issues", issue_count - i0, 6);
    check_int("bp_sb_empty", exp_q.size(), 0);
    check_int("bp_blk_idx", int'(blk_idx), 6);

    // Core never answers: timeout, then the queued block is issued
    done_delay = 0;
    b  = rand_blk(70);
    bb = rand_blk(71);
    push_blk(b, acc, stl);
    push_blk(bb, acc, stl);
    bus.in_valid = 1'b0;
    wait_valid(20, t);
    repeat (64) @(negedge clk);
    check_int("to_err_early", int'(err_timeout), 0);
    check_int("to_idx_early", int'(blk_idx), 6);
    @(negedge clk);
    check_int("to_err_set", int'(err_timeout), 1);
    check_int("to_idx_adv", int'(blk_idx), 7);
    @(negedge clk);
    check_int("to_next_issue", int'(bus.cavlc_valid), 1);
    check_blk("to_next_coef", bus.cavlc_coef, bb);
    repeat (3) @(negedge clk);
    check_int("to_err_sticky", int'(err_timeout), 1);

    // Reset in WAIT with two blocks queued, then a late done
    do_reset();
    check_int("rst2_err", int'(err_timeout), 0);
    for (int i = 0; i < 3; i++) push_blk(rand_blk(80 + i), acc, stl);
    bus.in_valid = 1'b0;
    check_int("mid_in_ready_full", int'(bus.in_ready), 0);
    check_int("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check_int("mid_rst_in_ready", int'(bus.in_ready), 1);
    check_int("mid_rst_idx", int'(blk_idx), 0);
    check_int("mid_rst_busy", int'(busy), 0);
    check_int("mid_rst_valid", int'(bus.cavlc_valid), 0);
    check_blk("mid_rst_coef", bus.cavlc_coef, '0);
    i0 = issue_count;
    bus.cavlc_done = 1'b1;
    @(negedge clk);
    bus.cavlc_done = 1'b0;
    repeat (3) @(negedge clk);
    check_int("late_done_idx", int'(blk_idx), 0);
    check_int("late_done_busy", int'(busy), 0);
    check_int("late_done_issue", issue_count - i0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
